imem_axi_rd_resp: RTL and testbench
===================================

# imem_axi_rd_resp

AXI4 read-channel responder backing the instruction-fetch path: accepts burst read requests on AR (INCR or FIXED, up to 256 beats of 64 bits) and returns data beats on R from an internal 64-bit-word memory after a programmable latency. It sits on the bus behind the icache refill master and replaces the behavioural memory model in simulation and FPGA builds. A side load port preloads program images.

## Interface
- MEM_DEPTH, 4096, number of 64-bit words; power of two
- BASE_ADDR, 32'h8000_0000, byte address of word 0; must be 8-byte aligned
- RD_LATENCY, 2, cycles from AR handshake edge to first rvalid; legal 1..15
- clk  in  1  clock; all logic on posedge
- rst  in  1  reset, asynchronous, active-high
- araddr  in  32  burst start byte address
- arvalid  in  1  request valid
- arburst  in  2  00 FIXED, 01 INCR, others unsupported
- arlen  in  8  beats minus one
- arsize  in  3  log2 bytes per beat; 0..3 supported
- arready  out  1  request accepted when arvalid&arready
- rdata  out  64  beat data
- rresp  out  2  00 OKAY, 10 SLVERR
- rvalid  out  1  beat valid
- rlast  out  1  final beat of burst
- rready  in  1  master accepts beat when rvalid&rready
- ld_en  in  1  load-port write strobe
- ld_addr  in  log2(MEM_DEPTH)  load word index
- ld_data  in  64  load word data

## Operation
- States: IDLE, WAIT, BURST. Only one outstanding burst; no AR pipelining.
- IDLE: arready=1. On arvalid&arready capture araddr, arburst, arlen, arsize; load beat counter with arlen; load latency counter with RD_LATENCY-1; go WAIT (or BURST directly when RD_LATENCY=1).
- WAIT: arready=0, rvalid=0; decrement latency counter; at zero go BURST and present beat 0.
- BURST: rvalid=1. Beat advances on rvalid&rready. rlast=1 exactly when beat counter is 0. Handshake on rlast beat -> IDLE.
- Beat address: beat 0 = captured araddr. INCR: next = addr + (1<<arsize), 32-bit modulo wrap, no 4 KB boundary check. FIXED: unchanged.
- Word select: index = (addr - BASE_ADDR)>>3. Narrow sizes (arsize<3) return the full 64-bit word containing addr; master selects lanes.
- rresp=10 and rdata=0 for a beat when addr < BASE_ADDR or index >= MEM_DEPTH. Bursts with arburst not in {00,01} or arsize>3: every beat SLVERR, rdata=0, full arlen+1 beats still returned with rlast.
- rdata/rresp registered, loaded when a beat is presented; held stable while rvalid&~rready.
- Load port writes array on posedge when ld_en, in any state. Beat capture and load to the same word in the same cycle returns the old value.
- Memory contents not affected by rst.

## Timing
- Reset values: arready=1, rvalid=0, rlast=0, rresp=00, rdata=0; state IDLE; counters 0. Outputs reach reset values asynchronously on rst assertion.
- Reset mid-burst: burst abandoned; rvalid/rlast drop immediately; no further beats after release.
- AR handshake at edge T -> rvalid first high in cycle beginning at edge T+RD_LATENCY.
- With rready held high: one beat per cycle, arlen+1 consecutive cycles.
- rready low: beat, rlast, rresp, rdata frozen; no timeout.
- arready returns 1 the cycle after the rlast handshake; earliest next first beat is RD_LATENCY cycles after that new handshake.
- arvalid outside IDLE ignored (arready=0); master must hold it.
- arlen=0: single beat with rlast=1.

## Test plan
- Preload words 8..16 with 0x1000+i; AR araddr=0x8000_0040, INCR, arlen=8, arsize=3, rready=1 -> arready low next cycle, first rvalid 2 cycles after handshake, 9 beats 0x1008..0x1010, rlast only on beat 9, rresp 00.
- Same burst, rready toggled 1,0,0,1,... -> each beat held unchanged during stalls, sequence and count identical, no beat dropped or duplicated.
- FIXED burst araddr=0x8000_0008, arlen=3 -> 4 beats all equal word 1; arsize=2, INCR, araddr=0x8000_0004, arlen=1 -> beats word 0 then word 1.
- araddr=0x8000_7FF8 (last word, MEM_DEPTH=4096), INCR arlen=1 -> beat 0 OKAY with stored data, beat 1 SLVERR rdata=0, rlast on beat 1; araddr=0x0000_0000 -> all beats SLVERR.
- arburst=10, arlen=2 -> 3 SLVERR beats with rlast on third; next request accepted normally.
- Assert rst during beat 3 of an 8-beat burst -> rvalid/rlast 0 same cycle, arready 1; after release a new arlen=0 request returns one correct beat.

Source files
------------

// File: rtl/imem_axi_rd_resp.sv
`default_nettype none
// ============================================================================
// Module   : imem_axi_rd_resp
// Purpose  : AXI4 read-channel responder for the instruction-fetch path.
//            Serves INCR/FIXED bursts of up to 256 64-bit beats from an
//            internal word memory after a programmable latency. A side load
//            port preloads program images.
// Revision : 1.0 - initial release
// ============================================================================
module imem_axi_rd_resp #(
    parameter int          MEM_DEPTH  = 4096,
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int          RD_LATENCY = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [31:0]                  araddr,
    input  logic                         arvalid,
    input  logic [1:0]                   arburst,
    input  logic [7:0]                   arlen,
    input  logic [2:0]                   arsize,
    output logic                         arready,
    output logic [63:0]                  rdata,
    output logic [1:0]                   rresp,
    output logic                         rvalid,
    output logic                         rlast,
    input  logic                         rready,
    input  logic                         ld_en,
    input  logic [$clog2(MEM_DEPTH)-1:0] ld_addr,
    input  logic [63:0]                  ld_data
);
    localparam int         c_IDX_W       = $clog2(MEM_DEPTH);
    localparam logic [3:0] c_LAT_INIT    = 4'(RD_LATENCY - 1);
    localparam logic [1:0] c_RESP_OKAY   = 2'b00;
    localparam logic [1:0] c_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_BURST = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [63:0]        r_mem [MEM_DEPTH];

    logic [31:0]        r_addr;
    logic [7:0]         r_beats;
    logic [3:0]         r_lat;
    logic [1:0]         r_size;
    logic               r_fixed;
    logic               r_bad;
    logic [63:0]        r_rdata;
    logic [1:0]         r_rresp;

    logic               w_ar_hs;
    logic               w_r_hs;
    logic               w_req_bad;
    logic               w_present;
    logic [31:0]        w_addr_next;
    logic [31:0]        w_beat_addr;
    logic [31:0]        w_beat_word;
    logic               w_beat_bad;
    logic               w_beat_err;
    logic [c_IDX_W-1:0] w_beat_idx;

    assign arready = (r_state == S_IDLE);
    assign rvalid  = (r_state == S_BURST);
    assign rlast   = rvalid && (r_beats == 8'd0);
    assign rdata   = r_rdata;
    assign rresp   = r_rresp;

    assign w_ar_hs = arvalid && arready;
    assign w_r_hs  = rvalid && rready;

    // Reserved burst types (10/11) and beats wider than 64 bits are errored
    assign w_req_bad = arburst[1] || arsize[2];

    assign w_addr_next = r_fixed ? r_addr : (r_addr + (32'd1 << r_size));

    // Word index relative to the base; the range check catches both
    // addresses below the base (they wrap to huge offsets) and past the end
    assign w_beat_word = (w_beat_addr - BASE_ADDR) >> 3;
    assign w_beat_idx  = w_beat_word[c_IDX_W-1:0];
    assign w_beat_err  = w_beat_bad || (w_beat_addr < BASE_ADDR) ||
                         (w_beat_word >= 32'(MEM_DEPTH));

    // Next state, and which address (if any) is presented as a beat this edge
    always_comb begin
        w_state_nxt = r_state;
        w_present   = 1'b0;
        w_beat_addr = r_addr;
        w_beat_bad  = r_bad;
        case (r_state)
            S_IDLE: begin
                if (w_ar_hs) begin
                    w_beat_addr = araddr;
                    w_beat_bad  = w_req_bad;
                    if (RD_LATENCY == 1) begin
                        w_state_nxt = S_BURST;
                        w_present   = 1'b1;
                    end else begin
                        w_state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (r_lat == 4'd0) begin
                    w_state_nxt = S_BURST;
                    w_present   = 1'b1;
                end
            end
            S_BURST: begin
                if (w_r_hs) begin
                    if (rlast) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_beat_addr = w_addr_next;
                        w_present   = 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Burst context, counters and the registered beat payload
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr  <= 32'd0;
            r_beats <= 8'd0;
            r_lat   <= 4'd0;
            r_size  <= 2'd0;
            r_fixed <= 1'b0;
            r_bad   <= 1'b0;
            r_rdata <= 64'd0;
            r_rresp <= c_RESP_OKAY;
        end else begin
            if (w_ar_hs) begin
                r_addr  <= araddr;
                r_beats <= arlen;
                r_lat   <= c_LAT_INIT;
                r_size  <= arsize[1:0];
                r_fixed <= ~arburst[0];
                r_bad   <= w_req_bad;
            end else if ((r_state == S_WAIT) && (r_lat != 4'd0)) begin
                r_lat <= r_lat - 4'd1;
            end
            if (w_r_hs && !rlast) begin
                r_addr  <= w_addr_next;
                r_beats <= r_beats - 8'd1;
            end
            if (w_present) begin
                r_rdata <= w_beat_err ? 64'd0 : r_mem[w_beat_idx];
                r_rresp <= w_beat_err ? c_RESP_SLVERR : c_RESP_OKAY;
            end
        end
    end

    // Load port; memory contents survive reset. A same-edge beat read sees
    // the previous word value.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            r_mem[ld_addr] <= ld_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_axi_rd_resp.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_axi_rd_resp
// Purpose  : Self-checking bench for imem_axi_rd_resp: directed vector table,
//            hand sequences for load collision and mid-burst reset, and
//            randomized bursts against a behavioural memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_axi_rd_resp;
    localparam int          DEPTH = 4096;
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          LAT   = 2;

    logic        clk;
    logic        rst;
    logic [31:0] araddr;
    logic        arvalid;
    logic [1:0]  arburst;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic        arready;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rlast;
    logic        rready;
    logic        ld_en;
    logic [11:0] ld_addr;
    logic [63:0] ld_data;

    logic [63:0] model [DEPTH];
    int          n_chk;
    int          n_fail;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  burst;
        logic [7:0]  len;
        logic [2:0]  size;
        int          mode;
        logic [63:0] first_d;
        logic [1:0]  first_r;
        logic [63:0] last_d;
        logic [1:0]  last_r;
    } vec_t;

    vec_t vecs [10];

    imem_axi_rd_resp #(
        .MEM_DEPTH (DEPTH),
        .BASE_ADDR (BASE),
        .RD_LATENCY(LAT)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .araddr (araddr),
        .arvalid(arvalid),
        .arburst(arburst),
        .arlen  (arlen),
        .arsize (arsize),
        .arready(arready),
        .rdata  (rdata),
        .rresp  (rresp),
        .rvalid (rvalid),
        .rlast  (rlast),
        .rready (rready),
        .ld_en  (ld_en),
        .ld_addr(ld_addr),
        .ld_data(ld_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    // Expected beat k from the burst rules: address of beat k in closed form,
    // then the range / legality decision and a memory lookup.
    function automatic void exp_beat(input logic [31:0] a, input logic [1:0] b,
                                     input logic [2:0] sz, input int k,
                                     output logic [63:0] d, output logic [1:0] r);
        logic [31:0] ak;
        logic [31:0] word;
        ak   = (b == 2'b00) ? a : a + 32'(k) * (32'd1 << sz);
        word = (ak - BASE) / 8;
        if (b > 2'd1 || sz > 3'd3 || ak < BASE || word >= 32'(DEPTH)) begin
            d = 64'd0;
            r = 2'b10;
        end else begin
            d = model[int'(word)];
            r = 2'b00;
        end
    endfunction

    // mode 0: rready always high; 1: pattern 1,0,0 repeating; 2: random
    task automatic run_burst(input logic [31:0] a, input logic [1:0] b,
                             input logic [7:0] len, input logic [2:0] sz,
                             input int mode, input string nm,
                             output logic [63:0] fd, output logic [1:0] fr,
                             output logic [63:0] ldv, output logic [1:0] lr);
        int          lat;
        int          k;
        int          cyc;
        logic        rr;
        logic [63:0] ed;
        logic [1:0]  er;
        fd  = '1;
        fr  = '1;
        ldv = '1;
        lr  = '1;
        @(negedge clk);
        chk({nm, "_arready_idle"}, arready, 1);
        araddr  = a;
        arburst = b;
        arlen   = len;
        arsize  = sz;
        arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        chk({nm, "_arready_busy"}, arready, 0);
        lat = 0;
        while (!rvalid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, "_latency"}, lat, LAT);
        if (!rvalid) return;
        k   = 0;
        cyc = 0;
        while (k <= int'(len) && cyc < 4000) begin
            if (!rvalid) begin
                chk({nm, "_rvalid"}, rvalid, 1);
                break;
            end
            exp_beat(a, b, sz, k, ed, er);
            chk($sformatf("%s_data%0d", nm, k), rdata, ed);
            chk($sformatf("%s_resp%0d", nm, k), rresp, er);
            chk($sformatf("%s_rlast%0d", nm, k), rlast, (k == int'(len)));
            if (k == 0) begin
                fd = rdata;
                fr = rresp;
            end
            if (k == int'(len)) begin
                ldv = rdata;
                lr  = rresp;
            end
            case (mode)
                0:       rr = 1'b1;
                1:       rr = (cyc % 3 == 0);
                default: rr = 1'($urandom_range(0, 1));
            endcase
            rready = rr;
            @(negedge clk);
            cyc++;
            if (rr) k++;
        end
        rready = 1'b0;
        chk({nm, "_beat_count"}, k, int'(len) + 1);
        chk({nm, "_rvalid_end"}, rvalid, 0);
        chk({nm, "_arready_end"}, arready, 1);
    endtask

    initial begin
        logic [63:0] fd;
        logic [63:0] ldv;
        logic [63:0] old21;
        logic [1:0]  fr;
        logic [1:0]  lr;
        logic [31:0] ra;
        logic [1:0]  rb;
        logic [2:0]  rs;
        int          lat;

        n_chk   = 0;
        n_fail  = 0;
        rst     = 1'b1;
        araddr  = 32'd0;
        arvalid = 1'b0;
        arburst = 2'b01;
        arlen   = 8'd0;
        arsize  = 3'd3;
        rready  = 1'b0;
        ld_en   = 1'b0;
        ld_addr = 12'd0;
        ld_data = 64'd0;

        // Reset state (load port is usable during reset)
        repeat (3) @(negedge clk);
        chk("reset_arready", arready, 1);
        chk("reset_rvalid", rvalid, 0);
        chk("reset_rlast", rlast, 0);
        chk("reset_rresp", rresp, 0);
        chk("reset_rdata", rdata, 0);

        for (int i = 0; i < DEPTH; i++) begin
            logic [63:0] v;
            v = {$urandom, $urandom};
            if (i >= 8 && i <= 16) v = 64'h1000 + 64'(i);
            if (i == 0)            v = 64'h0000_0000_A5A5_0000;
            if (i == 1)            v = 64'h1111_2222_3333_4444;
            if (i == DEPTH - 1)    v = 64'hFEED_FACE_0000_0FFF;
            @(negedge clk);
            ld_en   = 1'b1;
            ld_addr = 12'(i);
            ld_data = v;
            model[i] = v;
        end
        @(negedge clk);
        ld_en = 1'b0;
        rst   = 1'b0;

        vecs[0] = '{32'h8000_0040, 2'b01, 8'd8, 3'd3, 0, 64'h1008, 2'b00, 64'h1010, 2'b00};
        vecs[1] = '{32'h8000_0040, 2'b01, 8'd8, 3'd3, 1, 64'h1008, 2'b00, 64'h1010, 2'b00};
        vecs[2] = '{32'h8000_0008, 2'b00, 8'd3, 3'd3, 0, 64'h1111_2222_3333_4444, 2'b00,
                    64'h1111_2222_3333_4444, 2'b00};
        vecs[3] = '{32'h8000_0004, 2'b01, 8'd1, 3'd2, 0, 64'h0000_0000_A5A5_0000, 2'b00,
                    64'h1111_2222_3333_4444, 2'b00};
        vecs[4] = '{32'h8000_7FF8, 2'b01, 8'd1, 3'd3, 0, 64'hFEED_FACE_0000_0FFF, 2'b00,
                    64'd0, 2'b10};
        vecs[5] = '{32'h0000_0000, 2'b01, 8'd3, 3'd3, 0, 64'd0, 2'b10, 64'd0, 2'b10};
        vecs[6] = '{32'h8000_0040, 2'b10, 8'd2, 3'd3, 0, 64'd0, 2'b10, 64'd0, 2'b10};
        vecs[7] = '{32'h8000_0048, 2'b01, 8'd0, 3'd3, 0, 64'h1009, 2'b00, 64'h1009, 2'b00};
        vecs[8] = '{32'h8000_0040, 2'b01, 8'd1, 3'd4, 1, 64'd0, 2'b10, 64'd0, 2'b10};
        vecs[9] = '{32'h8000_0047, 2'b01, 8'd1, 3'd0, 1, 64'h1008, 2'b00, 64'h1009, 2'b00};

        foreach (vecs[i]) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            run_burst(vecs[i].addr, vecs[i].burst, vecs[i].len, vecs[i].size,
                      vecs[i].mode, nm, fd, fr, ldv, lr);
            chk({nm, "_first_data"}, fd, vecs[i].first_d);
            chk({nm, "_first_resp"}, fr, vecs[i].first_r);
            chk({nm, "_last_data"}, ldv, vecs[i].last_d);
            chk({nm, "_last_resp"}, lr, vecs[i].last_r);
        end

        // Load to word 21 on the same edge that beat 1 (word 21) is captured
        old21 = model[21];
        @(negedge clk);
        araddr  = BASE + 32'd160;
        arburst = 2'b01;
        arlen   = 8'd1;
        arsize  = 3'd3;
        arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        lat = 0;
        while (!rvalid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("coll_latency", lat, LAT);
        chk("coll_beat0", rdata, model[20]);
        rready  = 1'b1;
        ld_en   = 1'b1;
        ld_addr = 12'd21;
        ld_data = 64'hDEAD_BEEF_0000_0021;
        @(negedge clk);
        ld_en   = 1'b0;
        rready  = 1'b0;
        model[21] = 64'hDEAD_BEEF_0000_0021;
        chk("coll_beat1_old", rdata, old21);
        chk("coll_rlast", rlast, 1);
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        chk("coll_done", rvalid, 0);
        run_burst(BASE + 32'd168, 2'b01, 8'd0, 3'd3, 0, "coll_new", fd, fr, ldv, lr);
        chk("coll_new_data", fd, 64'hDEAD_BEEF_0000_0021);

        // Reset during beat 3 of an 8-beat burst
        @(negedge clk);
        araddr  = BASE + 32'h40;
        arburst = 2'b01;
        arlen   = 8'd7;
        arsize  = 3'd3;
        arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        lat = 0;
        while (!rvalid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("rstb_latency", lat, LAT);
        rready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rstb_beat3", rdata, model[10]);
        rst = 1'b1;
        #1;
        chk("rstb_rvalid", rvalid, 0);
        chk("rstb_rlast", rlast, 0);
        chk("rstb_arready", arready, 1);
        @(negedge clk);
        rst    = 1'b0;
        rready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rstb_no_beats", rvalid, 0);
        run_burst(BASE + 32'h58, 2'b01, 8'd0, 3'd3, 0, "rstb_after", fd, fr, ldv, lr);
        chk("rstb_after_data", fd, model[11]);

        // Randomized bursts against the model
        for (int t = 0; t < 40; t++) begin
            int sel;
            sel = $urandom_range(0, 9);
            if (sel == 0)      ra = $urandom;
            else if (sel == 1) ra = BASE + 32'h7FC0 + 32'($urandom_range(0, 63));
            else               ra = BASE + 32'($urandom_range(0, 32'h7FFF));
            rb = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
            rs = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
            run_burst(ra, rb, 8'($urandom_range(0, 15)), rs, $urandom_range(0, 2),
                      $sformatf("rnd%0d", t), fd, fr, ldv, lr);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
